// File: rtl/icache_line_filler.sv
// ---------------------------------------------------------------------------
// icache_line_filler
//
// Purpose:
//   Fill engine for the 16x8-word direct-mapped instruction cache. On a
//   miss it reads the 8-word line containing PC from instruction memory,
//   one word at a time with at most one read in flight. It then pulses
//   `update` for one cycle so the cache can write w0..w7. The CPU stays
//   stalled until that write has happened.
//
// Ports:
//   CLK, RST     clock (rising edge), asynchronous active-high reset
//   PC           fetch address, held stable by the stall
//   miss         combinational miss flag from the cache
//   mem_rden     1-cycle read strobe to memory
//   mem_addr     word-aligned read address, valid while mem_rden=1
//   mem_rdata    read data, valid while mem_rvalid=1
//   mem_rvalid   read-data strobe, at least 1 cycle after mem_rden
//   update       1-cycle line-write strobe to the cache
//   w0..w7       assembled line, wN = word at line offset N
//   stall        freeze PC/fetch: miss | busy
//   busy         FSM not in IDLE
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, WAIT=2, UPDATE=3)
//
// Handshake:
//   mem_rden is a single-cycle request and carries no ready. Each request
//   is answered by exactly one mem_rvalid cycle. The next request is issued
//   only after that response, so only one read is ever outstanding.
//   mem_rvalid is honoured only in WAIT.
//
// Configuration:
//   ICACHE_CRIT_WORD_FIRST_EN  when defined, the fill starts at the word
//   PC points to and wraps modulo 8. Each word still lands in w[offset].
//   When undefined, words are fetched in ascending order 0..7.
// ---------------------------------------------------------------------------
module icache_line_filler #(
  parameter int ADDR_W     = 32,
  parameter int WORD_OFF_W = 3,
  parameter int BYTE_OFF_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC,
  input  logic              miss,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              update,
  output logic [31:0]       w0,
  output logic [31:0]       w1,
  output logic [31:0]       w2,
  output logic [31:0]       w3,
  output logic [31:0]       w4,
  output logic [31:0]       w5,
  output logic [31:0]       w6,
  output logic [31:0]       w7,
  output logic              stall,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int LINE_OFF = WORD_OFF_W + BYTE_OFF_W;
  localparam int TAG_W    = ADDR_W - LINE_OFF;
  localparam int WORDS    = 1 << WORD_OFF_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_W-1:0]        tag_q, tag_d;     // line base without its zero offset bits
  logic [WORD_OFF_W-1:0]   beat_q, beat_d;   // word offset of the read in flight
  logic [WORD_OFF_W-1:0]   count_q, count_d; // captures so far in this fill
  logic                    mem_rden_q, mem_rden_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    update_q, update_d;
  logic [31:0]             w_q [WORDS];
  logic [31:0]             w_d [WORDS];

  logic [WORD_OFF_W-1:0]   start_beat;
  logic [WORD_OFF_W-1:0]   beat_inc;
  logic                    unused_pc_bits;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  assign start_beat = PC[LINE_OFF-1:BYTE_OFF_W];
`else
  assign start_beat = '0;
`endif

  // Line-offset bits of PC only matter for critical-word-first.
  assign unused_pc_bits = ^PC[LINE_OFF-1:0];

  assign beat_inc = beat_q + WORD_OFF_W'(1);

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    count_d    = count_q;
    mem_rden_d = 1'b0;
    mem_addr_d = mem_addr_q;
    update_d   = 1'b0;
    w_d        = w_q;

    case (state_q)
      S_IDLE: begin
        if (miss) begin
          tag_d      = PC[ADDR_W-1:LINE_OFF];
          beat_d     = start_beat;
          count_d    = '0;
          // Outputs are registered, so the first read is launched on the
          // same edge that leaves IDLE. That edge enters ISSUE.
          mem_rden_d = 1'b1;
          mem_addr_d = {PC[ADDR_W-1:LINE_OFF], start_beat, {BYTE_OFF_W{1'b0}}};
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          w_d[beat_q] = mem_rdata;
          beat_d      = beat_inc;
          count_d     = count_q + WORD_OFF_W'(1);
          if (count_q == '1) begin
            update_d = 1'b1;
            state_d  = S_UPDATE;
          end else begin
            mem_rden_d = 1'b1;
            mem_addr_d = {tag_q, beat_inc, {BYTE_OFF_W{1'b0}}};
            state_d    = S_ISSUE;
          end
        end
      end

      S_UPDATE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      beat_q     <= '0;
      count_q    <= '0;
      mem_rden_q <= 1'b0;
      mem_addr_q <= '0;
      update_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) w_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      beat_q     <= beat_d;
      count_q    <= count_d;
      mem_rden_q <= mem_rden_d;
      mem_addr_q <= mem_addr_d;
      update_q   <= update_d;
      for (int i = 0; i < WORDS; i++) w_q[i] <= w_d[i];
    end
  end

  assign mem_rden  = mem_rden_q;
  assign mem_addr  = mem_addr_q;
  assign update    = update_q;
  assign busy      = (state_q != S_IDLE);
  // Combinational, so the CPU freezes in the same cycle the miss appears.
  assign stall     = miss | busy;
  assign state_dbg = state_q;

  assign w0 = w_q[0];
  assign w1 = w_q[1];
  assign w2 = w_q[2];
  assign w3 = w_q[3];
  assign w4 = w_q[4];
  assign w5 = w_q[5];
  assign w6 = w_q[6];
  assign w7 = w_q[7];

endmodule

// File: tb/tb_icache_line_filler.sv
// ---------------------------------------------------------------------------
// tb_icache_line_filler
//
// Bench for icache_line_filler. A memory model answers each read with
// data = addr ^ 32'hA5A5_0000, after a fixed or random latency.
//
// Expected read addresses and expected lines are queued when a fill is
// started. A negedge monitor pops and compares them whenever the DUT shows
// mem_rden or update. It also checks that only one read is in flight.
// ---------------------------------------------------------------------------
module tb_icache_line_filler;

  localparam logic [31:0] KEY  = 32'hA5A5_0000;
  localparam logic [31:0] SPUR = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        miss;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        update;
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic        stall;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  icache_line_filler dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .miss       (miss),
    .mem_rden   (mem_rden),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .update     (update),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .w5         (w5),
    .w6         (w6),
    .w7         (w7),
    .stall      (stall),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0]  exp_addr_q [$];
  logic [255:0] exp_line_q [$];
  int           rden_log_cyc [$];
  logic [31:0]  rden_log_addr [$];
  int compared = 0;
  int failed   = 0;
  int upd_cnt  = 0;
  int upd_cyc  = 0;
  int outstanding = 0;

  int mem_lat  = 1;   // 0 = random 1..5 per word
  bit spur_req = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] exp_line(input logic [31:0] pc);
    logic [255:0] l;
    logic [31:0]  a;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      a = {pc[31:5], i[2:0], 2'b00};
      l[i*32 +: 32] = a ^ KEY;
    end
    return l;
  endfunction

  function automatic logic [2:0] start_of(input logic [31:0] pc);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    return pc[4:2];
`else
    return pc[4:2] & 3'b000;
`endif
  endfunction

  task automatic push_addrs(input logic [31:0] pc, input int n);
    logic [2:0] o;
    for (int i = 0; i < n; i++) begin
      o = start_of(pc) + i[2:0];
      exp_addr_q.push_back({pc[31:5], o, 2'b00});
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    bit          pend;
    int          dly;
    logic [31:0] paddr;
    pend = 1'b0;
    dly = 0;
    paddr = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge CLK);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (pend) begin
        dly--;
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = paddr ^ KEY;
          pend = 1'b0;
        end
      end
      if (spur_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = SPUR;
        spur_req   = 1'b0;
      end
      if (mem_rden) begin
        pend  = 1'b1;
        paddr = mem_addr;
        dly   = (mem_lat == 0) ? $urandom_range(1, 5) : mem_lat;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RST) begin
      outstanding = 0;
    end else begin
      if (mem_rvalid) outstanding = 0;
      if (mem_rden) begin
        chk("reads outstanding", outstanding, 0);
        outstanding = 1;
        rden_log_cyc.push_back(cyc);
        rden_log_addr.push_back(mem_addr);
        if (exp_addr_q.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected rden: addr %0h, none expected", mem_addr);
        end else begin
          chk("rden addr", mem_addr, exp_addr_q.pop_front());
        end
      end
      if (update) begin
        upd_cnt++;
        upd_cyc = cyc;
        if (exp_line_q.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected update: line %0h, none expected", {w7, w6, w5, w4, w3, w2, w1, w0});
        end else begin
          chk("update line", {w7, w6, w5, w4, w3, w2, w1, w0}, exp_line_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+1. Returns at the negedge+1 of the update cycle, with miss still high.
  task automatic do_fill(input logic [31:0] pc, input int lat, input bit spur_issue,
                         input logic [255:0] prev_line, output int t_miss);
    int n0;
    rden_log_cyc.delete();
    rden_log_addr.delete();
    push_addrs(pc, 8);
    exp_line_q.push_back(exp_line(pc));
    mem_lat = lat;
    n0 = upd_cnt;
    PC = pc;
    miss = 1'b1;
    t_miss = cyc;
    #1;
    chk("stall same cycle as miss", stall, 1);
    chk("not busy at miss cycle", busy, 0);
    if (spur_issue) begin
      @(negedge CLK);          // cycle T: request a spurious beat in T+1 (ISSUE)
      spur_req = 1'b1;
      @(negedge CLK);          // T+1
      chk("state ISSUE at T+1", state_dbg, 1);
      @(negedge CLK);          // T+2: any capture in ISSUE would be visible now
      chk("line after issue spurious", {w7, w6, w5, w4, w3, w2, w1, w0}, prev_line);
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      #1;
      if (upd_cnt != n0) break;
    end
    chk("update seen", upd_cnt - n0, 1);
    chk("rden count", rden_log_cyc.size(), 8);
    if (lat == 1 && rden_log_cyc.size() > 0) begin
      chk("first rden cycle", rden_log_cyc[0], t_miss + 1);
      chk("update cycle", upd_cyc, t_miss + 17);
    end
  endtask

  task automatic drop_miss_check();
    @(posedge CLK);
    #1;
    miss = 1'b0;
    @(negedge CLK);
    chk("stall low after update", stall, 0);
    chk("busy low after update", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1, t2, n;
    RST = 1'b1;
    miss = 1'b0;
    PC = '0;
    #12;
    chk("reset rden", mem_rden, 0);
    chk("reset addr", mem_addr, 0);
    chk("reset update", update, 0);
    chk("reset line", {w7, w6, w5, w4, w3, w2, w1, w0}, 0);
    chk("reset busy", busy, 0);
    chk("reset stall", stall, 0);
    chk("reset state", state_dbg, 0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Basic fill, 1-cycle memory.
    do_fill(32'h0000_0124, 1, 1'b0, '0, t1);
    chk("basic w0", w0, 32'hA5A5_0120);
    chk("basic w7", w7, 32'hA5A5_013C);
    drop_miss_check();

    // Spurious beat while IDLE.
    spur_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("line after idle spurious", {w7, w6, w5, w4, w3, w2, w1, w0}, exp_line(32'h0000_0124));
    @(posedge CLK);
    #1;

    // Spurious beat during ISSUE.
    do_fill(32'h0000_0124, 1, 1'b1, exp_line(32'h0000_0124), t1);
    drop_miss_check();
    @(posedge CLK);
    #1;

    // Random latency 1..5 per word.
    do_fill(32'h0000_0124, 0, 1'b0, '0, t1);
    drop_miss_check();
    @(posedge CLK);
    #1;

    // Reset after the 4th capture, with a late response still pending.
    push_addrs(32'h0000_0124, 4);
    mem_lat = 3;
    PC = 32'h0000_0124;
    miss = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (mem_rvalid) n++;
      if (n == 4) break;
    end
    chk("reached 4th capture", n, 4);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    miss = 1'b0;
    #1;
    chk("rst line", {w7, w6, w5, w4, w3, w2, w1, w0}, 0);
    chk("rst update", update, 0);
    chk("rst rden", mem_rden, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst stall", stall, 0);
    chk("rst reads consumed", exp_addr_q.size(), 0);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("line after late rvalid", {w7, w6, w5, w4, w3, w2, w1, w0}, 0);
    chk("idle after late rvalid", busy, 0);
    @(posedge CLK);
    #1;
    do_fill(32'h0000_0124, 1, 1'b0, '0, t1);
    drop_miss_check();
    @(posedge CLK);
    #1;

    // Back-to-back fills, second miss at T+18.
    do_fill(32'h0000_0040, 1, 1'b0, '0, t1);
    @(posedge CLK);
    #1;
    do_fill(32'h0000_0800, 1, 1'b0, '0, t2);
    if (rden_log_addr.size() > 0)
      chk("b2b second base", rden_log_addr[0] & 32'hFFFF_FFE0, 32'h0000_0800);
    if (rden_log_cyc.size() > 0)
      chk("b2b second first rden", rden_log_cyc[0] - t1, 19);
    drop_miss_check();
    @(posedge CLK);
    #1;

    // Miss in the middle of a line.
    do_fill(32'h0000_0134, 1, 1'b0, '0, t1);
    chk("w5 from 0x134", w5, 32'hA5A5_0134);
    if (rden_log_addr.size() == 8) begin
`ifdef ICACHE_CRIT_WORD_FIRST_EN
      chk("cwf first addr", rden_log_addr[0], 32'h0000_0134);
      chk("cwf fourth addr", rden_log_addr[3], 32'h0000_0120);
      chk("cwf last addr", rden_log_addr[7], 32'h0000_0130);
`else
      chk("seq first addr", rden_log_addr[0], 32'h0000_0120);
      chk("seq last addr", rden_log_addr[7], 32'h0000_013C);
`endif
    end
    drop_miss_check();

    repeat (5) @(negedge CLK);
    chk("addr queue drained", exp_addr_q.size(), 0);
    chk("line queue drained", exp_line_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
